// File: rtl/load_store_unit.sv
// load_store_unit
//   Byte-addressed, little-endian load/store unit sitting between a pipeline
//   request port and a single-ported 32-bit data memory.
//   - Loads: one read cycle; byte/half lanes are extracted and sign- or
//     zero-extended.
//   - Stores: word stores, and byte/half stores at lane 0, write directly
//     with a byte mask.
//   - Byte/half stores at a nonzero lane use read-modify-write. The full
//     word is read, the lane(s) are merged, and the word is written back
//     with mask 1111.
//   Optional feature macro: MISALIGN_TRAP_EN. When it is defined, a
//   misaligned half/word request completes at once with resp_err = 1 and
//   makes no memory access. When it is undefined, resp_err is tied to 0 and
//   the low address bits that cause the misalignment are ignored.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid / req_ready    request handshake (ready only while idle)
//   req_we, req_size,        request: store flag, size (00 byte, 01 half,
//   req_signed, req_addr,    1x word), load sign-extend flag, byte address,
//   req_wdata                and right-justified store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata, resp_err     load result / misalignment fault
//                            (both held until the next completion)
//   mem_ce, mem_we, mem_rd   memory chip/write/read enables
//   mem_addr                 word-aligned memory address
//   mem_wdata, mem_wmask     memory write data and byte write mask
//   mem_rmask                memory byte read mask
//   mem_rdata                combinational memory read data
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_ce,
    output logic              mem_we,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    output logic [3:0]        mem_rmask,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, DONE} state_t;

    state_t            state_q, state_d;
    logic              we_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rword_q;
    logic [31:0]       resp_rdata_q, resp_rdata_d;

    // Byte offset actually used for an access. Halves drop addr[0] and words
    // drop addr[1:0]. This only matters for misaligned requests when they
    // are not trapped.
    function automatic logic [1:0] eff_off(input logic [1:0] size, input logic [1:0] a);
        if (size == 2'b00)      return a;
        else if (size == 2'b01) return {a[1], 1'b0};
        else                    return 2'b00;
    endfunction

    logic       req_fire;
    logic [1:0] req_off;
    logic [1:0] lane_off;
    logic       rmw_store;

    assign req_fire  = req_valid && (state_q == IDLE);
    assign req_off   = eff_off(req_size, req_addr[1:0]);
    assign lane_off  = eff_off(size_q, addr_q[1:0]);
    // The registered access is a sub-word store to a nonzero lane.
    assign rmw_store = !size_q[1] && (lane_off != 2'b00);

`ifdef MISALIGN_TRAP_EN
    logic req_mis;
    logic resp_err_q, resp_err_d;
    assign req_mis = ((req_size == 2'b01) && req_addr[0]) ||
                     (req_size[1] && (req_addr[1:0] != 2'b00));
`endif

    // Load extraction: shift the addressed lane down to bit 0, then extend it.
    logic [31:0] rd_shift;
    logic [31:0] load_data;
    always_comb begin
        rd_shift  = mem_rdata >> {lane_off, 3'b000};
        load_data = mem_rdata;
        if (size_q == 2'b00)
            load_data = {{24{signed_q & rd_shift[7]}}, rd_shift[7:0]};
        else if (size_q == 2'b01)
            load_data = {{16{signed_q & rd_shift[15]}}, rd_shift[15:0]};
    end

    // Read-modify-write merge: replace the addressed lane(s) of the word
    // that was read in RMW_RD with the shifted store data.
    logic [3:0]  lane_mask;
    logic [31:0] wdata_shift;
    logic [31:0] merged;
    always_comb begin
        lane_mask   = ((size_q == 2'b00) ? 4'b0001 : 4'b0011) << lane_off;
        wdata_shift = wdata_q << {lane_off, 3'b000};
        merged      = rword_q;
        for (int i = 0; i < 4; i++)
            if (lane_mask[i]) merged[8*i +: 8] = wdata_shift[8*i +: 8];
    end

    // Next-state logic and response capture.
    always_comb begin
        state_d      = state_q;
        resp_rdata_d = resp_rdata_q;
`ifdef MISALIGN_TRAP_EN
        resp_err_d   = resp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_fire) begin
`ifdef MISALIGN_TRAP_EN
                    if (req_mis) begin
                        state_d      = DONE;
                        resp_rdata_d = 32'd0;
                        resp_err_d   = 1'b1;
                    end else
`endif
                    if (!req_we)
                        state_d = RD;
                    else if (req_size[1] || (req_off == 2'b00))
                        state_d = WR;
                    else
                        state_d = RMW_RD;
                end
            end
            RD: begin
                state_d      = DONE;
                resp_rdata_d = load_data;
`ifdef MISALIGN_TRAP_EN
                resp_err_d   = 1'b0;
`endif
            end
            RMW_RD: state_d = WR;
            WR: begin
                state_d      = DONE;
                resp_rdata_d = 32'd0;
`ifdef MISALIGN_TRAP_EN
                resp_err_d   = 1'b0;
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            rword_q      <= 32'd0;
            resp_rdata_q <= 32'd0;
`ifdef MISALIGN_TRAP_EN
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            resp_rdata_q <= resp_rdata_d;
`ifdef MISALIGN_TRAP_EN
            resp_err_q   <= resp_err_d;
`endif
            if (req_fire) begin
                we_q     <= req_we;
                size_q   <= req_size;
                signed_q <= req_signed;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (state_q == RMW_RD)
                rword_q <= mem_rdata;
        end
    end

    // Memory and handshake outputs are decoded from registered state only.
    // An asynchronous reset therefore drops them to 0 immediately.
    always_comb begin
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        mem_wmask = 4'b0000;
        mem_rmask = 4'b0000;
        case (state_q)
            RD, RMW_RD: begin
                mem_ce    = 1'b1;
                mem_rd    = 1'b1;
                mem_rmask = 4'b1111;
                mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
            end
            WR: begin
                mem_ce   = 1'b1;
                mem_we   = we_q;
                mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
                if (rmw_store) begin
                    mem_wdata = merged;
                    mem_wmask = 4'b1111;
                end else begin
                    mem_wdata = wdata_q;
                    mem_wmask = (size_q == 2'b00) ? 4'b0001 :
                                (size_q == 2'b01) ? 4'b0011 : 4'b1111;
                end
            end
            default: ;
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign resp_rdata = resp_rdata_q;
`ifdef MISALIGN_TRAP_EN
    assign resp_err   = resp_err_q;
`else
    assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven testbench for load_store_unit. It includes a small
// word-addressed memory model, and word 0x10 is preset to 0x8899AABB.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_ce, mem_we, mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask, mem_rmask;
    logic [31:0] mem_rdata;

    logic        mem_init;
    logic [31:0] mem [16];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rmask(mem_rmask),
        .mem_rdata(mem_rdata)
    );

    // Memory model: combinational read, byte-masked write on the clock edge.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++)
                mem[i] <= (i == 4) ? 32'h8899AABB : 32'(i) * 32'h01010101;
        end else if (mem_ce && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end
    assign mem_rdata = mem[mem_addr[5:2]];

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic        exp_ce;
        logic        exp_wr;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_wdata;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int exp_lat, input logic exp_ce, input logic exp_wr,
                                input logic [3:0] exp_wmask, input logic [31:0] exp_wdata);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_ce = exp_ce; v.exp_wr = exp_wr; v.exp_wmask = exp_wmask; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Apply one request. Track the memory-side activity on every cycle until
    // the response arrives, then check the response and the DONE->IDLE step.
    task automatic run_vec(input int n, input vec_t v);
        int          lat;
        logic        seen_ce, seen_we, rmask_bad;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic [31:0] rdata;
        @(negedge clk);
        chk($sformatf("v%0d ready", n), 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1; seen_ce = 1'b0; seen_we = 1'b0; rmask_bad = 1'b0;
        wmask = 4'b0000; wdata = 32'd0;
        while (!resp_valid && lat < 8) begin
            if (mem_ce) seen_ce = 1'b1;
            if (mem_rd && mem_rmask !== 4'b1111) rmask_bad = 1'b1;
            if (mem_we) begin
                seen_we = 1'b1;
                wmask   = mem_wmask;
                wdata   = mem_wdata;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = resp_rdata;
        $display("txn %0d: we=%0b size=%0d sgn=%0b addr=0x%08h wdata=0x%08h -> lat=%0d rdata=0x%08h err=%0b",
                 n, v.we, v.size, v.sgn, v.addr, v.wdata, lat, rdata, resp_err);
        chk($sformatf("v%0d resp_valid", n), 32'(resp_valid), 32'd1);
        chk($sformatf("v%0d latency", n), 32'(lat), 32'(v.exp_lat));
        chk($sformatf("v%0d rdata", n), rdata, v.exp_rdata);
        chk($sformatf("v%0d err", n), 32'(resp_err), 32'(v.exp_err));
        chk($sformatf("v%0d mem_ce seen", n), 32'(seen_ce), 32'(v.exp_ce));
        chk($sformatf("v%0d mem_we seen", n), 32'(seen_we), 32'(v.exp_wr));
        chk($sformatf("v%0d rmask", n), 32'(rmask_bad), 32'd0);
        chk($sformatf("v%0d mem_ce in DONE", n), 32'(mem_ce), 32'd0);
        if (v.exp_wr) begin
            chk($sformatf("v%0d wmask", n), 32'(wmask), 32'(v.exp_wmask));
            chk($sformatf("v%0d wdata", n), wdata, v.exp_wdata);
        end
        @(posedge clk);
        #1;
        chk($sformatf("v%0d pulse width", n), 32'(resp_valid), 32'd0);
        chk($sformatf("v%0d ready after DONE", n), 32'(req_ready), 32'd1);
        chk($sformatf("v%0d rdata hold", n), resp_rdata, rdata);
    endtask

    vec_t vecs [20];
    logic saw_we;
    logic saw_resp;

    initial begin
        // Vector table. Stores change memory, so the order matters.
        vecs[0]  = mk(0, 2'b00, 1, 32'h11, 0, 32'hFFFFFFAA, 0, 2, 1, 0, 0, 0);
        vecs[1]  = mk(0, 2'b01, 0, 32'h12, 0, 32'h00008899, 0, 2, 1, 0, 0, 0);
        vecs[2]  = mk(0, 2'b10, 0, 32'h10, 0, 32'h8899AABB, 0, 2, 1, 0, 0, 0);
        vecs[3]  = mk(0, 2'b00, 0, 32'h11, 0, 32'h000000AA, 0, 2, 1, 0, 0, 0);
        vecs[4]  = mk(0, 2'b01, 1, 32'h12, 0, 32'hFFFF8899, 0, 2, 1, 0, 0, 0);
        vecs[5]  = mk(0, 2'b01, 1, 32'h10, 0, 32'hFFFFAABB, 0, 2, 1, 0, 0, 0);
        vecs[6]  = mk(0, 2'b00, 1, 32'h13, 0, 32'hFFFFFF88, 0, 2, 1, 0, 0, 0);
`ifdef MISALIGN_TRAP_EN
        vecs[7]  = mk(0, 2'b10, 1, 32'h13, 0, 32'h00000000, 1, 1, 0, 0, 0, 0);
`else
        vecs[7]  = mk(0, 2'b10, 1, 32'h13, 0, 32'h8899AABB, 0, 2, 1, 0, 0, 0);
`endif
        vecs[8]  = mk(1, 2'b00, 0, 32'h12, 32'h00000055, 0, 0, 3, 1, 1, 4'b1111, 32'h8855AABB);
        vecs[9]  = mk(0, 2'b10, 0, 32'h10, 0, 32'h8855AABB, 0, 2, 1, 0, 0, 0);
        vecs[10] = mk(1, 2'b00, 0, 32'h10, 32'hABCDEF77, 0, 0, 2, 1, 1, 4'b0001, 32'hABCDEF77);
        vecs[11] = mk(0, 2'b10, 0, 32'h10, 0, 32'h8855AA77, 0, 2, 1, 0, 0, 0);
        vecs[12] = mk(1, 2'b01, 0, 32'h12, 32'h00001234, 0, 0, 3, 1, 1, 4'b1111, 32'h1234AA77);
        vecs[13] = mk(1, 2'b10, 0, 32'h14, 32'hDEADBEEF, 0, 0, 2, 1, 1, 4'b1111, 32'hDEADBEEF);
        vecs[14] = mk(0, 2'b11, 1, 32'h14, 0, 32'hDEADBEEF, 0, 2, 1, 0, 0, 0);
        vecs[15] = mk(1, 2'b00, 0, 32'h15, 32'h00000000, 0, 0, 3, 1, 1, 4'b1111, 32'hDEAD00EF);
        vecs[16] = mk(0, 2'b10, 0, 32'h14, 0, 32'hDEAD00EF, 0, 2, 1, 0, 0, 0);
`ifdef MISALIGN_TRAP_EN
        vecs[17] = mk(0, 2'b01, 0, 32'h11, 0, 32'h00000000, 1, 1, 0, 0, 0, 0);
        vecs[18] = mk(1, 2'b01, 0, 32'h11, 32'h0000BEEF, 0, 1, 1, 0, 0, 0, 0);
        vecs[19] = mk(0, 2'b10, 0, 32'h10, 0, 32'h1234AA77, 0, 2, 1, 0, 0, 0);
`else
        vecs[17] = mk(0, 2'b01, 0, 32'h11, 0, 32'h0000AA77, 0, 2, 1, 0, 0, 0);
        vecs[18] = mk(1, 2'b01, 0, 32'h11, 32'h0000BEEF, 0, 0, 2, 1, 1, 4'b0011, 32'h0000BEEF);
        vecs[19] = mk(0, 2'b10, 0, 32'h10, 0, 32'h1234BEEF, 0, 2, 1, 0, 0, 0);
`endif

        rst = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;

        // State while reset is held.
        repeat (2) @(posedge clk);
        #1;
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset resp_err", 32'(resp_err), 32'd0);
        chk("reset mem_ce", 32'(mem_ce), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_init = 1'b0;
        #1;
        chk("ready after reset", 32'(req_ready), 32'd1);

        for (int i = 0; i < 20; i++) run_vec(i, vecs[i]);

        // Reset pulse during RMW_RD of a byte store to 0x12. The memory is
        // restored to its preset contents first.
        @(negedge clk);
        mem_init = 1'b1;
        @(negedge clk);
        mem_init = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h12; req_wdata = 32'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("abort in RMW_RD mem_rd", 32'(mem_rd), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort async mem_ce", 32'(mem_ce), 32'd0);
        chk("abort async mem_rd", 32'(mem_rd), 32'd0);
        saw_we = 1'b0; saw_resp = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (mem_we) saw_we = 1'b1;
            if (resp_valid) saw_resp = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort ready after release", 32'(req_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (mem_we) saw_we = 1'b1;
            if (resp_valid) saw_resp = 1'b1;
        end
        $display("txn abort: store byte 0x55 @0x12 reset in RMW_RD -> mem_we=%0b resp=%0b word=0x%08h",
                 saw_we, saw_resp, mem[4]);
        chk("abort mem_we never", 32'(saw_we), 32'd0);
        chk("abort no resp", 32'(saw_resp), 32'd0);
        chk("abort word unchanged", mem[4], 32'h8899AABB);
        run_vec(20, mk(0, 2'b10, 0, 32'h10, 0, 32'h8899AABB, 0, 2, 1, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
